// File: rtl/ahb_slave_arbiter_pkg.sv
// Shared types and constants for the per-slave AHB arbiter.
package ahb_slave_arbiter_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_INCR   = 3'd1,
        HBURST_WRAP4  = 3'd2,
        HBURST_INCR4  = 3'd3,
        HBURST_WRAP8  = 3'd4,
        HBURST_INCR8  = 3'd5,
        HBURST_WRAP16 = 3'd6,
        HBURST_INCR16 = 3'd7
    } hburst_t;

    // Beat counter load values: beats remaining after the NONSEQ beat.
    localparam logic [3:0] BEATS_INCR4  = 4'd3;
    localparam logic [3:0] BEATS_INCR8  = 4'd7;
    localparam logic [3:0] BEATS_INCR16 = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_BURST = 2'd2,
        ST_LOCK  = 2'd3
    } arb_state_t;

    // Counter load for a burst type; SINGLE and undefined INCR load zero.
    function automatic logic [3:0] burst_load(input logic [2:0] hburst);
        logic [3:0] load;
        unique case (hburst_t'(hburst))
            HBURST_WRAP4,  HBURST_INCR4:  load = BEATS_INCR4;
            HBURST_WRAP8,  HBURST_INCR8:  load = BEATS_INCR8;
            HBURST_WRAP16, HBURST_INCR16: load = BEATS_INCR16;
            default:                      load = 4'd0;
        endcase
        return load;
    endfunction

endpackage

// File: rtl/ahb_slave_arbiter_picker.sv
// Combinational masked priority picker: first requester scanning upward
// from ptr+1 with wrap-around. ptr = NUM_MASTERS-1 gives fixed priority.
module ahb_rr_picker #(
    parameter int unsigned NUM_MASTERS = 4,
    parameter int unsigned SEL_W       = $clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [SEL_W-1:0]       ptr,
    output logic [NUM_MASTERS-1:0] grant,
    output logic [SEL_W-1:0]       idx,
    output logic                   any
);

    logic             found;
    logic [SEL_W-1:0] cand;

    // Scan candidates in rotated order and keep the first requester.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
            cand = SEL_W'((32'(ptr) + k) % NUM_MASTERS);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/ahb_slave_arbiter.sv
// Per-slave AHB arbiter: one-hot grant plus binary select, burst and lock
// holding, data-phase owner tracking.
// Build option: AHB_ARB_FIXED_PRIO_EN selects fixed priority (lowest index
// wins, no round-robin pointer); default is round-robin.
module ahb_slave_arbiter
    import ahb_slave_arbiter_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = 4,
    parameter int unsigned SEL_W       = $clog2(NUM_MASTERS)
) (
    input  logic                   hclk,
    input  logic                   hreset,
    input  logic [NUM_MASTERS-1:0] hreq,
    input  logic [NUM_MASTERS-1:0] hlock,
    input  logic [1:0]             htrans,
    input  logic [2:0]             hburst,
    input  logic                   hready,
    output logic [NUM_MASTERS-1:0] hgrant,
    output logic [SEL_W-1:0]       sel,
    output logic [SEL_W-1:0]       hmaster_data,
    output logic                   data_valid,
    output logic                   hmastlock
);

    arb_state_t             state, state_nxt;
    logic [3:0]             cnt, cnt_nxt;
    logic [NUM_MASTERS-1:0] hgrant_nxt;
    logic [SEL_W-1:0]       sel_nxt;
    logic                   rearb;

    logic [SEL_W-1:0]       pick_ptr;
    logic [NUM_MASTERS-1:0] pick_grant;
    logic [SEL_W-1:0]       pick_idx;
    logic                   pick_any;

`ifdef AHB_ARB_FIXED_PRIO_EN
    assign pick_ptr = SEL_W'(NUM_MASTERS - 1);
`else
    logic [SEL_W-1:0] rr_ptr;

    // Round-robin pointer follows the most recent arbitration winner.
    always_ff @(posedge hclk) begin
        if (hreset)
            rr_ptr <= SEL_W'(NUM_MASTERS - 1);
        else if (rearb && pick_any)
            rr_ptr <= pick_idx;
    end

    assign pick_ptr = rr_ptr;
`endif

    ahb_rr_picker #(
        .NUM_MASTERS (NUM_MASTERS),
        .SEL_W       (SEL_W)
    ) u_picker (
        .req   (hreq),
        .ptr   (pick_ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // Next-state logic: burst/lock holding and re-arbitration decisions.
    // A NONSEQ that neither locks nor starts a fixed-length burst is itself
    // a re-arbitration point, so SINGLE and undefined INCR yield per beat.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        hgrant_nxt = hgrant;
        sel_nxt    = sel;
        rearb      = 1'b0;
        if (hready) begin
            unique case (state)
                ST_IDLE: rearb = 1'b1;
                ST_GRANT: begin
                    if (htrans == HTRANS_NONSEQ) begin
                        cnt_nxt = burst_load(hburst);
                        if (hlock[sel])
                            state_nxt = ST_LOCK;
                        else if (burst_load(hburst) != 4'd0)
                            state_nxt = ST_BURST;
                        else
                            rearb = 1'b1;
                    end else begin
                        rearb = 1'b1;
                    end
                end
                ST_BURST: begin
                    if (htrans == HTRANS_NONSEQ && hlock[sel]) begin
                        state_nxt = ST_LOCK;
                    end else if (htrans == HTRANS_SEQ) begin
                        cnt_nxt = cnt - 4'd1;
                        if (cnt == 4'd1)
                            state_nxt = ST_GRANT;
                    end
                end
                ST_LOCK: begin
                    if (!hlock[sel] && htrans == HTRANS_IDLE)
                        state_nxt = ST_GRANT;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
        if (rearb) begin
            if (pick_any) begin
                hgrant_nxt = pick_grant;
                sel_nxt    = pick_idx;
                state_nxt  = ST_GRANT;
            end else begin
                hgrant_nxt = '0;
                state_nxt  = ST_IDLE;
            end
        end
    end

    // Address-phase state register.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            hgrant <= '0;
            sel    <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            hgrant <= hgrant_nxt;
            sel    <= sel_nxt;
        end
    end

    // Data-phase owner: takes the address-phase select as each phase completes.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            hmaster_data <= '0;
            data_valid   <= 1'b0;
        end else if (hready) begin
            hmaster_data <= sel;
            data_valid   <= (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
        end
    end

    assign hmastlock = (state == ST_LOCK);

endmodule

// File: tb/tb_ahb_slave_arbiter.sv
// Randomized bench: behavioural masters and arbitration model, per-cycle
// output checks, and a scoreboard for data-phase ownership.
module tb_ahb_slave_arbiter;
    import ahb_slave_arbiter_pkg::*;

    localparam int N = 4;

    logic         hclk = 1'b0;
    logic         hreset;
    logic [N-1:0] hreq, hlock;
    logic [1:0]   htrans;
    logic [2:0]   hburst;
    logic         hready;
    logic [N-1:0] hgrant;
    logic [1:0]   sel, hmaster_data;
    logic         data_valid, hmastlock;

    always #5 hclk = ~hclk;

    ahb_slave_arbiter #(.NUM_MASTERS(N)) dut (
        .hclk(hclk), .hreset(hreset), .hreq(hreq), .hlock(hlock),
        .htrans(htrans), .hburst(hburst), .hready(hready),
        .hgrant(hgrant), .sel(sel), .hmaster_data(hmaster_data),
        .data_valid(data_valid), .hmastlock(hmastlock)
    );

    int tests = 0;
    int fails = 0;
    int exp_q[$];

    // Reference model state
    int m_owner, m_beats, m_last, m_sel, m_md;
    bit m_locked, m_dv;

    // Master jobs
    bit         job_act[N], job_lock[N], job_started[N];
    int         job_len[N];
    logic [2:0] job_burst[N];
    bit         rst_done;

    function automatic int beats_of(input logic [2:0] b);
        if (b < 3'd2) return 1;
        return 4 << ((int'(b) - 2) / 2);
    endfunction

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, got, exp, $time);
        end
    endtask

    task automatic new_job(input int i, input bit single_only);
        job_act[i] = 1; job_started[i] = 0;
        if (!single_only && $urandom_range(0, 7) == 0) begin
            job_lock[i] = 1; job_burst[i] = HBURST_SINGLE; job_len[i] = $urandom_range(2, 3);
        end else begin
            job_lock[i] = 0;
            job_burst[i] = single_only ? 3'd0 : 3'($urandom_range(0, 7));
            job_len[i] = beats_of(job_burst[i]);
        end
    endtask

    task automatic drive();
        int o;
        o = m_owner;
        for (int i = 0; i < N; i++) begin
            hreq[i]  = job_act[i];
            hlock[i] = job_act[i] && job_lock[i] && job_len[i] > 0;
        end
        htrans = HTRANS_IDLE; hburst = HBURST_SINGLE;
        if (o >= 0 && job_act[o]) begin
            if (job_len[o] == 0)
                htrans = HTRANS_IDLE;
            else if (job_lock[o] || !job_started[o]) begin
                htrans = HTRANS_NONSEQ; hburst = job_burst[o];
            end else begin
                htrans = ($urandom_range(0, 5) == 0) ? HTRANS_BUSY : HTRANS_SEQ;
                hburst = job_burst[o];
            end
        end
        // Owner dropping its request inside a fixed burst must not matter.
        if (m_beats > 0 && o >= 0 && $urandom_range(0, 3) == 0) hreq[o] = 1'b0;
        hready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic model_step();
        bit xfer, re;
        int win, c;
        if (hreset) begin
            m_owner = -1; m_beats = 0; m_locked = 0; m_last = N - 1;
            m_sel = 0; m_md = 0; m_dv = 0;
            exp_q.delete();
            return;
        end
        if (!hready) return;
        xfer = (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
        m_md = m_sel;
        m_dv = xfer;
        if (xfer) exp_q.push_back(m_owner);
        re = 0;
        if (m_owner < 0) re = 1;
        else if (m_locked) begin
            if (!hlock[m_owner] && htrans == HTRANS_IDLE) m_locked = 0;
        end else if (m_beats > 0) begin
            if (htrans == HTRANS_NONSEQ && hlock[m_owner]) begin m_locked = 1; m_beats = 0; end
            else if (htrans == HTRANS_SEQ) m_beats--;
        end else if (htrans == HTRANS_NONSEQ && hlock[m_owner]) m_locked = 1;
        else if (htrans == HTRANS_NONSEQ && beats_of(hburst) > 1) m_beats = beats_of(hburst) - 1;
        else re = 1;
        if (re) begin
            win = -1;
            for (int k = 1; k <= N; k++) begin
`ifdef AHB_ARB_FIXED_PRIO_EN
                c = k - 1;
`else
                c = (m_last + k) % N;
`endif
                if (win < 0 && hreq[c]) win = c;
            end
            m_owner = win;
            if (win >= 0) begin m_sel = win; m_last = win; end
        end
    endtask

    task automatic master_step(input int o);
        if (hready && o >= 0 && job_act[o]) begin
            if (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ) begin
                job_started[o] = 1; job_len[o]--;
                if (job_len[o] == 0 && !job_lock[o]) job_act[o] = 0;
            end else if (htrans == HTRANS_IDLE && job_lock[o] && job_len[o] == 0) begin
                job_act[o] = 0;
            end
        end
    endtask

    // Scoreboard monitor: one pop per completed data phase.
    always @(negedge hclk) begin
        if (!hreset && data_valid && hready) begin
            if (exp_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL data_owner: got %0d expected none (queue empty) at t=%0t", hmaster_data, $time);
            end else begin
                check("data_owner", 32'(hmaster_data), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        int o;
        logic [N-1:0] eg;
        hreset = 1; hreq = '0; hlock = '0; htrans = HTRANS_IDLE; hburst = HBURST_SINGLE; hready = 1;
        for (int i = 0; i < N; i++) begin job_act[i] = 0; job_len[i] = 0; job_lock[i] = 0; job_started[i] = 0; job_burst[i] = 3'd0; end
        m_owner = -1; m_beats = 0; m_locked = 0; m_last = N - 1; m_sel = 0; m_md = 0; m_dv = 0;
        rst_done = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            hreset = (cyc < 2);
            if (!rst_done && cyc >= 400 && (m_beats >= 3 || cyc == 700)) begin
                hreset = 1; rst_done = 1;
            end
            if (!hreset && cyc < 1300)
                for (int i = 0; i < N; i++)
                    if (!job_act[i] && $urandom_range(0, 4) == 0) new_job(i, 0);
            drive();
            @(posedge hclk); #1;
            o = m_owner;
            model_step();
            if (hreset) begin
                // After any reset every master asks for a SINGLE: master 0 must win first.
                for (int i = 0; i < N; i++) new_job(i, 1);
            end else begin
                master_step(o);
            end
            eg = (m_owner < 0) ? '0 : N'(1 << m_owner);
            check("hgrant", 32'(hgrant), 32'(eg));
            check("sel", 32'(sel), 32'(m_sel));
            check("data_valid", 32'(data_valid), 32'(m_dv));
            check("hmastlock", 32'(hmastlock), 32'(m_locked));
            check("hmaster_data", 32'(hmaster_data), 32'(m_md));
        end
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
